shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller for a 4-bit bidirectional universal shift register with '194-style mode pins (s1:s0 = 00 hold, 01 shift right, 10 shift left, 11 parallel load).
- Accepts one command at a time over a valid/ready handshake and drives the mode, serial-input, parallel-data and clear pins for the required number of clocks.
- Reads the register outputs back to implement rotates, and pulses done when the command completes.
- Sits between a host or control FSM and the shift register. It shares the register clock.

Parameters:
- CNT_W, 2, width of the shift-count field. The number of shifts performed is cmd_cnt+1, so the range is 1..2^CNT_W.

Ports:
- cp  input  1  clock. Rising edge, shared with the shift register.
- mr  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110 CLR, 111 reserved (executes as NOP).
- cmd_cnt  input  CNT_W  shift count minus 1. Ignored for NOP, LOAD and CLR.
- cmd_data  input  4  parallel load value, used by LOAD.
- ser_in  input  1  external serial bit, used by SHR and SHL.
- q  input  4  shift register outputs (q[0] = first stage).
- s0  output  1  mode select bit 0.
- s1  output  1  mode select bit 1.
- dsr  output  1  shift-right serial input.
- dsl  output  1  shift-left serial input.
- p  output  4  parallel data to the register.
- reg_clr  output  1  active-high clear request to the register, one cycle wide.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Outputs s0, s1, p, reg_clr, busy and done are registered. cmd_ready is decoded from state only.
- dsr and dsl are combinational:
  - dsr = q[3] while a ROR is active, else ser_in.
  - dsl = q[0] while a ROL is active, else ser_in.
- Reset (mr=1 at a cp edge):
  - state=IDLE, s1:s0=00, p=0, reg_clr=0, busy=0, done=0, remaining count=0.
  - Reset mid-command abandons the command immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, busy=0, s1:s0=00.
  - Acceptance happens when cmd_valid=1 at a cp edge. At that edge the op, count and data are latched and the state moves to RUN (NOP/reserved go straight to DONE).
  - RUN outputs take effect in the cycle after acceptance.
- RUN:
  - cmd_ready=0, busy=1.
  - LOAD: s1:s0=11 and p=cmd_data for exactly 1 cycle.
  - SHR/ROR: s1:s0=01 for cmd_cnt+1 cycles.
  - SHL/ROL: s1:s0=10 for cmd_cnt+1 cycles.
  - CLR: reg_clr=1, s1:s0=00 for 1 cycle.
  - An internal down-counter is loaded with cmd_cnt. At each edge in RUN, if the counter is 0 the state goes to DONE and s1:s0 goes to 00; otherwise the counter decrements.
- DONE: done=1, busy=0, cmd_ready=0, s1:s0=00 for 1 cycle, then IDLE.
- Throughput: back-to-back commands have a minimum spacing of (RUN cycles + 2) clocks. cmd_valid asserted while not ready is held off; no command is ever dropped or duplicated.
- Register-side effect: the register changes on each edge during which the mode is non-hold. An N-shift command therefore shifts exactly N times. The register is unchanged in IDLE and DONE.
- Latency from acceptance edge to done high:
  - LOAD/CLR: 2 edges.
  - Shifts: cnt+2 edges.
  - NOP: 1 edge.
- cmd_cnt at maximum (2^CNT_W-1) gives 2^CNT_W shifts. A full rotate of 4 returns the original value.
- p holds its last loaded value outside LOAD; only s1:s0=11 makes it significant.

Test Plan:
- Reset: mr=1 for 2 cycles during a SHR cnt=3 → s1:s0=00, busy=0, done never pulses, cmd_ready=1 one cycle after mr drops.
- LOAD 4'b1011 then SHR cnt=1, ser_in=0 → q goes 1011→(q[0]=0 shifted in twice) with s1:s0=01 for exactly 2 cycles; done pulses once after each command.
- ROL cnt=3 from q=4'b0001 → four shifts with dsl=q[0] fed back; q returns to 0001; done occurs 5 edges after acceptance.
- SHL cnt=0, ser_in=1, q=0000 → exactly one shift left; q[3]=1, all other bits 0; s1:s0=10 for one cycle only.
- CLR then NOP, with cmd_valid held high continuously → reg_clr pulses once; the NOP is accepted only after the CLR's DONE cycle; cmd_ready pattern is 1,0,0,1,0,1.
- Reserved op 111 with cnt=3 → treated as NOP: no mode activity, done one cycle after acceptance.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer
//
// Command-driven controller for a 4-bit '194-style universal shift register.
// A host hands over one command at a time on a valid/ready handshake; the
// sequencer then drives the register's mode pins (s1:s0), serial inputs,
// parallel data and clear request for as many clocks as the command needs,
// and pulses done once the register has been updated.
//
// Mode encoding on s1:s0: 00 hold, 01 shift right, 10 shift left, 11 load.
// Shift right moves q[0] -> q[1] -> ... with dsr entering q[0]; shift left
// moves q[3] -> q[2] -> ... with dsl entering q[3].
//
// Ports
//   cp         in   clock, rising edge, shared with the shift register
//   mr         in   synchronous reset, active-high
//   cmd_valid  in   command present
//   cmd_ready  out  sequencer can accept a command (IDLE only)
//   cmd_op     in   000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL,
//                   110 CLR, 111 reserved (behaves as NOP)
//   cmd_cnt    in   shift count minus one (shifts only)
//   cmd_data   in   parallel load value (LOAD only)
//   ser_in     in   external serial bit for SHR / SHL
//   q          in   shift register outputs, q[0] is the first stage
//   s0, s1     out  registered mode select
//   dsr, dsl   out  combinational serial inputs (rotate feedback or ser_in)
//   p          out  registered parallel data, holds its last loaded value
//   reg_clr    out  registered one-cycle clear request
//   busy       out  registered, high while a command is running
//   done       out  registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_reg_sequencer #(
  parameter int CNT_W = 2
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       cmd_data,
  input  logic             ser_in,
  input  logic [3:0]       q,
  output logic             s0,
  output logic             s1,
  output logic             dsr,
  output logic             dsl,
  output logic [3:0]       p,
  output logic             reg_clr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

  // Mode the register must sit in while a given op is running.
  function automatic logic [1:0] op_mode(input logic [2:0] op);
    case (op)
      OP_LOAD:         op_mode = MODE_LOAD;
      OP_SHR, OP_ROR:  op_mode = MODE_SHR;
      OP_SHL, OP_ROL:  op_mode = MODE_SHL;
      default:         op_mode = MODE_HOLD;
    endcase
  endfunction

  // NOP and the reserved encoding never enter RUN.
  function automatic logic op_is_nop(input logic [2:0] op);
    op_is_nop = (op == OP_NOP) || (op == 3'b111);
  endfunction

  // Only the four shift/rotate ops take their length from cmd_cnt; LOAD and
  // CLR always run for a single cycle.
  function automatic logic op_uses_cnt(input logic [2:0] op);
    op_uses_cnt = (op == OP_SHR) || (op == OP_SHL) ||
                  (op == OP_ROR) || (op == OP_ROL);
  endfunction

  state_t           state_q,   state_d;
  logic [2:0]       op_q,      op_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       mode_q,    mode_d;
  logic [3:0]       p_q,       p_d;
  logic             reg_clr_q, reg_clr_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  // Rotation feedback only needs the two end stages of the register.
  logic unused_q_mid;
  assign unused_q_mid = ^q[2:1];

  // ---- next-state / registered-output decode ----
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    p_d       = p_q;
    reg_clr_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mode_d = MODE_HOLD;
        busy_d = 1'b0;
        if (cmd_valid) begin
          op_d = cmd_op;
          if (op_is_nop(cmd_op)) begin
            // Nothing to do to the register: complete on the next cycle.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            // Outputs for the first RUN cycle are set up here so that the
            // register acts on the very first edge spent in RUN.
            state_d   = ST_RUN;
            busy_d    = 1'b1;
            mode_d    = op_mode(cmd_op);
            cnt_d     = op_uses_cnt(cmd_op) ? cmd_cnt : CNT_ZERO;
            reg_clr_d = (cmd_op == OP_CLR);
            if (cmd_op == OP_LOAD) begin
              p_d = cmd_data;
            end
          end
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_ZERO) begin
          // Last active edge: drop to hold at the same edge the register
          // performs its final update.
          state_d = ST_DONE;
          mode_d  = MODE_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        mode_d  = MODE_HOLD;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        mode_d  = MODE_HOLD;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---- state and output registers ----
  always_ff @(posedge cp) begin
    if (mr) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      cnt_q     <= CNT_ZERO;
      mode_q    <= MODE_HOLD;
      p_q       <= 4'b0000;
      reg_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      p_q       <= p_d;
      reg_clr_q <= reg_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign s1        = mode_q[1];
  assign s0        = mode_q[0];
  assign p         = p_q;
  assign reg_clr   = reg_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Rotates close the loop through the register: the bit falling off one
  // end is presented on the serial input of the other end.
  assign dsr = ((state_q == ST_RUN) && (op_q == OP_ROR)) ? q[3] : ser_in;
  assign dsl = ((state_q == ST_RUN) && (op_q == OP_ROL)) ? q[0] : ser_in;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_sequencer
//
// Bench for shift_reg_sequencer. A behavioural '194 register is attached to
// the sequencer's pins so that the effect of each command on q can be
// compared with hand-derived values. Commands from a vector table are issued
// one at a time; their expectations go into a scoreboard queue when issued
// and are popped when done is seen. A few hand-written sequences cover reset
// during a command and back-to-back commands with cmd_valid held high.
// ---------------------------------------------------------------------------
module tb_shift_reg_sequencer;

  localparam int CNT_W = 2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic             cp = 1'b0;
  logic             mr;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       cmd_data;
  logic             ser_in;
  logic [3:0]       q;
  logic             s0, s1, dsr, dsl;
  logic [3:0]       p;
  logic             reg_clr, busy, done;

  logic [3:0]       reg_q;

  shift_reg_sequencer #(.CNT_W(CNT_W)) dut (
    .cp        (cp),
    .mr        (mr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .q         (q),
    .s0        (s0),
    .s1        (s1),
    .dsr       (dsr),
    .dsl       (dsl),
    .p         (p),
    .reg_clr   (reg_clr),
    .busy      (busy),
    .done      (done)
  );

  always #5 cp = ~cp;

  // Behavioural universal shift register sharing the clock.
  assign q = reg_q;
  always @(posedge cp) begin
    if (reg_clr) reg_q <= 4'b0000;
    else begin
      case ({s1, s0})
        2'b01:   reg_q <= {reg_q[2:0], dsr};
        2'b10:   reg_q <= {dsl, reg_q[3:1]};
        2'b11:   reg_q <= p;
        default: reg_q <= reg_q;
      endcase
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] cnt;
    logic [3:0] data;
    logic       sin;
    logic [3:0] exp_q;
    int         exp_lat;
    int         exp_mcyc;
    int         exp_clr;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    int         lat;
    int         mcyc;
    int         clr;
    logic [1:0] mode;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] cnt,
                              input logic [3:0] data, input logic sin,
                              input logic [3:0] eq, input int lat,
                              input int mcyc, input int clr);
    vec_t v;
    v.op = op; v.cnt = cnt; v.data = data; v.sin = sin;
    v.exp_q = eq; v.exp_lat = lat; v.exp_mcyc = mcyc; v.exp_clr = clr;
    return v;
  endfunction

  function automatic logic [1:0] exp_mode(input logic [2:0] op);
    case (op)
      OP_LOAD:        return 2'b11;
      OP_SHR, OP_ROR: return 2'b01;
      OP_SHL, OP_ROL: return 2'b10;
      default:        return 2'b00;
    endcase
  endfunction

  // Issue one command from IDLE, wait for done, score against the queue.
  task automatic run_cmd(input int idx, input vec_t v);
    exp_t e;
    exp_t got_e;
    int   lat, mcyc, ccyc, bad;
    bit   got;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge cp);
    check({tag, "_ready_pre"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_cnt   = v.cnt;
    cmd_data  = v.data;
    ser_in    = v.sin;
    e.q = v.exp_q; e.lat = v.exp_lat; e.mcyc = v.exp_mcyc;
    e.clr = v.exp_clr; e.mode = exp_mode(v.op);
    sb.push_back(e);
    lat = 0; mcyc = 0; ccyc = 0; bad = 0; got = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(posedge cp); #1;
      if (i == 1) cmd_valid = 1'b0;
      if ({s1, s0} != 2'b00) begin
        if ({s1, s0} == e.mode) mcyc++;
        else bad++;
      end
      if (reg_clr) ccyc++;
      if (done) begin
        got = 1;
        lat = i;
      end
    end
    check({tag, "_done_seen"}, got, 1);
    if (got && sb.size() > 0) begin
      got_e = sb.pop_front();
      check({tag, "_q"},        q,    got_e.q);
      check({tag, "_latency"},  lat,  got_e.lat);
      check({tag, "_mode_cyc"}, mcyc, got_e.mcyc);
      check({tag, "_bad_mode"}, bad,  0);
      check({tag, "_clr_cyc"},  ccyc, got_e.clr);
      check({tag, "_busy_at_done"}, busy, 0);
    end
    @(posedge cp); #1;
    check({tag, "_done_pulse_1cyc"}, done, 0);
    check({tag, "_ready_post"}, cmd_ready, 1);
    check({tag, "_q_stable"}, q, v.exp_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int clr_n;
    logic [5:0] rdy;
    logic [5:0] rdy_exp;

    tbl[0]  = mk(OP_CLR,  2'd0, 4'h0,    1'b0, 4'b0000, 2, 0, 1);
    tbl[1]  = mk(OP_LOAD, 2'd0, 4'b1011, 1'b0, 4'b1011, 2, 1, 0);
    tbl[2]  = mk(OP_SHR,  2'd1, 4'h0,    1'b0, 4'b1100, 3, 2, 0);
    tbl[3]  = mk(OP_LOAD, 2'd0, 4'b0001, 1'b0, 4'b0001, 2, 1, 0);
    tbl[4]  = mk(OP_ROL,  2'd3, 4'h0,    1'b0, 4'b0001, 5, 4, 0);
    tbl[5]  = mk(OP_ROL,  2'd0, 4'h0,    1'b0, 4'b1000, 2, 1, 0);
    tbl[6]  = mk(OP_ROR,  2'd1, 4'h0,    1'b0, 4'b0010, 3, 2, 0);
    tbl[7]  = mk(OP_CLR,  2'd3, 4'h0,    1'b0, 4'b0000, 2, 0, 1);
    tbl[8]  = mk(OP_SHL,  2'd0, 4'h0,    1'b1, 4'b1000, 2, 1, 0);
    tbl[9]  = mk(OP_SHR,  2'd2, 4'h0,    1'b1, 4'b0111, 4, 3, 0);
    tbl[10] = mk(OP_NOP,  2'd3, 4'h0,    1'b0, 4'b0111, 1, 0, 0);
    tbl[11] = mk(OP_RSV,  2'd3, 4'h0,    1'b0, 4'b0111, 1, 0, 0);
    tbl[12] = mk(OP_LOAD, 2'd3, 4'b1010, 1'b0, 4'b1010, 2, 1, 0);
    tbl[13] = mk(OP_ROR,  2'd3, 4'h0,    1'b0, 4'b1010, 5, 4, 0);
    tbl[14] = mk(OP_SHL,  2'd1, 4'h0,    1'b0, 4'b0010, 3, 2, 0);
    tbl[15] = mk(OP_ROR,  2'd0, 4'h0,    1'b1, 4'b0100, 2, 1, 0);

    // ---- reset state ----
    mr = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_cnt = '0;
    cmd_data = 4'h0; ser_in = 1'b0;
    repeat (2) @(posedge cp);
    @(negedge cp);
    mr = 1'b0;
    check("rst_ready",   cmd_ready, 1);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_mode",    {s1, s0}, 2'b00);
    check("rst_p",       p, 4'h0);
    check("rst_reg_clr", reg_clr, 0);

    // ---- table-driven commands ----
    for (int i = 0; i < 16; i++) run_cmd(i, tbl[i]);

    // ---- reset in the middle of SHR cnt=3 ----
    @(negedge cp);
    cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_cnt = 2'd3; ser_in = 1'b1;
    @(posedge cp); #1;
    cmd_valid = 1'b0;
    check("mid_accepted_busy", busy, 1);
    check("mid_mode_shr", {s1, s0}, 2'b01);
    @(negedge cp);
    mr = 1'b1;
    dn = 0;
    @(posedge cp); #1;
    if (done) dn++;
    check("mid_rst_mode", {s1, s0}, 2'b00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_p", p, 4'h0);
    @(posedge cp); #1;
    if (done) dn++;
    @(negedge cp);
    mr = 1'b0;
    @(posedge cp); #1;
    if (done) dn++;
    check("mid_ready_after_rst", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge cp); #1;
      if (done) dn++;
    end
    check("mid_no_done", dn, 0);
    check("mid_mode_idle", {s1, s0}, 2'b00);

    // ---- CLR then NOP with cmd_valid held high ----
    @(negedge cp);
    cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_cnt = 2'd0;
    rdy = '0; clr_n = 0; dn = 0;
    rdy[0] = cmd_ready;
    for (int k = 1; k <= 5; k++) begin
      @(posedge cp); #1;
      if (k == 1) cmd_op = OP_NOP;
      if (k == 4) cmd_valid = 1'b0;
      rdy[k] = cmd_ready;
      if (reg_clr) clr_n++;
      if (done) dn++;
    end
    rdy_exp = 6'b101001;  // bit k = cycle k: 1,0,0,1,0,1
    check("b2b_ready_pattern", rdy, rdy_exp);
    check("b2b_clr_pulses", clr_n, 1);
    check("b2b_done_pulses", dn, 2);
    check("b2b_q_cleared", q, 4'b0000);
    check("b2b_idle_ready", cmd_ready, 1);

    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
